// File: rtl/ext_pkg.sv
// Shared mode encodings and helpers for the registered immediate/load extender.
package ext_pkg;

  typedef enum logic [2:0] {
    EXT_SIGN = 3'b000,
    EXT_ZERO = 3'b001,
    EXT_LUI  = 3'b010,
    EXT_LB   = 3'b011,
    EXT_LBU  = 3'b100,
    EXT_LH   = 3'b101,
    EXT_LHU  = 3'b110,
    EXT_LW   = 3'b111
  } extMode_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational mode/lane extension of an immediate or loaded word.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int OFF_W = 2
) (
  input  logic [2:0]       mode,
  input  logic [IN_W-1:0]  imm,
  input  logic [OUT_W-1:0] word,
  input  logic [OFF_W-1:0] off,
  output logic [OUT_W-1:0] data
);

  function automatic logic [OUT_W-1:0] sextImm(input logic signed [IN_W-1:0] v);
    return OUT_W'(v);
  endfunction

  function automatic logic [OUT_W-1:0] sextByte(input logic signed [7:0] v);
    return OUT_W'(v);
  endfunction

  function automatic logic [OUT_W-1:0] sextHalf(input logic signed [15:0] v);
    return OUT_W'(v);
  endfunction

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  // Halfword lane ignores the low offset bit, so odd offsets round down.
  assign laneByte = word[8*int'(off) +: 8];
  assign laneHalf = word[16*int'(off >> 1) +: 16];

  always_comb begin
    data = '0;
    case (mode)
      EXT_SIGN: data = sextImm(imm);
      EXT_ZERO: data = OUT_W'(imm);
      EXT_LUI:  data = {imm, {(OUT_W-IN_W){1'b0}}};
      EXT_LB:   data = sextByte(laneByte);
      EXT_LBU:  data = OUT_W'(laneByte);
      EXT_LH:   data = sextHalf(laneHalf);
      EXT_LHU:  data = OUT_W'(laneHalf);
      EXT_LW:   data = word;
      default:  data = '0;
    endcase
  end

endmodule

// File: rtl/ext_pipe_unit.sv
// Registered extender with valid/ready handshake and one-entry skid buffer.
// Define EXT_MISALIGN_EN to flag odd-offset halfword loads on out_err.
module ext_pipe_unit
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_mode,
  input  logic [IN_W-1:0]               in_imm,
  input  logic [OUT_W-1:0]              in_word,
  input  logic [clog2(OUT_W/8)-1:0]     in_off,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic [TAG_W-1:0]              out_tag,
  output logic                          out_err
);

  localparam int OFF_W = clog2(OUT_W / 8);

  logic [OUT_W-1:0] extData_p0;
  logic             vld_p1;
  logic [OUT_W-1:0] data_p1;
  logic [TAG_W-1:0] tag_p1;
  logic             skidVld;
  logic [OUT_W-1:0] skidData;
  logic [TAG_W-1:0] skidTag;
  logic             accept;
  logic             advance;

  // Stage p0: combinational extension at the input
  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .OFF_W (OFF_W)
  ) uCore (
    .mode (in_mode),
    .imm  (in_imm),
    .word (in_word),
    .off  (in_off),
    .data (extData_p0)
  );

  assign in_ready = rst_n && !skidVld;
  assign accept   = in_valid && in_ready;
  assign advance  = !vld_p1 || out_ready;

  // Stage p1: output register, refilled from skid first to keep order
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      tag_p1  <= '0;
      skidVld <= 1'b0;
    end else if (advance) begin
      if (skidVld) begin
        vld_p1  <= 1'b1;
        data_p1 <= skidData;
        tag_p1  <= skidTag;
        skidVld <= 1'b0;
      end else if (accept) begin
        vld_p1  <= 1'b1;
        data_p1 <= extData_p0;
        tag_p1  <= in_tag;
      end else begin
        vld_p1  <= 1'b0;
      end
    end else if (accept) begin
      skidVld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!advance && accept) begin
      skidData <= extData_p0;
      skidTag  <= in_tag;
    end
  end

`ifdef EXT_MISALIGN_EN
  logic err_p0;
  logic err_p1;
  logic skidErr;

  assign err_p0 = ((in_mode == EXT_LH) || (in_mode == EXT_LHU)) && in_off[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_p1 <= 1'b0;
    end else if (advance) begin
      if (skidVld) begin
        err_p1 <= skidErr;
      end else if (accept) begin
        err_p1 <= err_p0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!advance && accept) begin
      skidErr <= err_p0;
    end
  end

  assign out_err = err_p1;
`else
  assign out_err = 1'b0;
`endif

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_tag   = tag_p1;

endmodule

// File: tb/tb_ext_pipe_unit.sv
// Directed self-checking bench for ext_pipe_unit (default 16/32/5 configuration).
module tb_ext_pipe_unit;
  import ext_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mode;
  logic [15:0] in_imm;
  logic [31:0] in_word;
  logic [1:0]  in_off;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;

  int nAssert;
  int nFail;

  ext_pipe_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_imm    (in_imm),
    .in_word   (in_word),
    .in_off    (in_off),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request at a negedge, let it be accepted, return at the next negedge.
  task automatic driveReq(input logic [2:0] mode, input logic [15:0] imm,
                          input logic [31:0] word, input logic [1:0] off,
                          input logic [4:0] tag);
    in_valid = 1'b1;
    in_mode  = mode;
    in_imm   = imm;
    in_word  = word;
    in_off   = off;
    in_tag   = tag;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nAssert++;
    if (out_valid !== 1'b0) begin nFail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    nAssert++;
    if (out_data !== 32'h0) begin nFail++; $display("FAIL rst_out_data: got %h want 00000000", out_data); end
    nAssert++;
    if (out_tag !== 5'd0 || out_err !== 1'b0) begin
      nFail++; $display("FAIL rst_tag_err: got tag %0d err %b want 0 0", out_tag, out_err);
    end
    nAssert++;
    if (in_ready !== 1'b0) begin nFail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    rst_n = 1'b1;
    #1;
    nAssert++;
    if (in_ready !== 1'b1) begin nFail++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_imm_modes;
    out_ready = 1'b1;
    driveReq(EXT_SIGN, 16'h8001, 32'h0, 2'd0, 5'd3);
    nAssert++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFF8001 || out_tag !== 5'd3) begin
      nFail++; $display("FAIL sign: got v%b %h tag %0d want v1 ffff8001 tag 3", out_valid, out_data, out_tag);
    end
    driveReq(EXT_ZERO, 16'h8001, 32'h0, 2'd0, 5'd4);
    nAssert++;
    if (out_valid !== 1'b1 || out_data !== 32'h00008001 || out_tag !== 5'd4) begin
      nFail++; $display("FAIL zero: got v%b %h tag %0d want v1 00008001 tag 4", out_valid, out_data, out_tag);
    end
    driveReq(EXT_LUI, 16'h1234, 32'h0, 2'd0, 5'd5);
    nAssert++;
    if (out_valid !== 1'b1 || out_data !== 32'h12340000 || out_tag !== 5'd5) begin
      nFail++; $display("FAIL lui: got v%b %h tag %0d want v1 12340000 tag 5", out_valid, out_data, out_tag);
    end
    @(negedge clk);
    nAssert++;
    if (out_valid !== 1'b0) begin nFail++; $display("FAIL idle_after_lui: got v%b want 0", out_valid); end
  endtask

  task automatic test_load_byte;
    logic [31:0] expB [4];
    expB = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      driveReq(EXT_LB, 16'h0, 32'h80FF7F01, 2'(i), 5'(10 + i));
      nAssert++;
      if (out_valid !== 1'b1 || out_data !== expB[i] || out_tag !== 5'(10 + i)) begin
        nFail++;
        $display("FAIL lb_off%0d: got v%b %h tag %0d want v1 %h tag %0d",
                 i, out_valid, out_data, out_tag, expB[i], 10 + i);
      end
    end
    driveReq(EXT_LBU, 16'h0, 32'h80FF7F01, 2'd3, 5'd14);
    nAssert++;
    if (out_data !== 32'h00000080) begin nFail++; $display("FAIL lbu_off3: got %h want 00000080", out_data); end
    driveReq(EXT_LBU, 16'h0, 32'h80FF7F01, 2'd2, 5'd15);
    nAssert++;
    if (out_data !== 32'h000000FF) begin nFail++; $display("FAIL lbu_off2: got %h want 000000ff", out_data); end
  endtask

  task automatic test_load_half;
    logic expErr;
`ifdef EXT_MISALIGN_EN
    expErr = 1'b1;
`else
    expErr = 1'b0;
`endif
    out_ready = 1'b1;
    driveReq(EXT_LH, 16'h0, 32'h80007FFF, 2'd2, 5'd16);
    nAssert++;
    if (out_data !== 32'hFFFF8000 || out_err !== 1'b0) begin
      nFail++; $display("FAIL lh_off2: got %h err %b want ffff8000 err 0", out_data, out_err);
    end
    driveReq(EXT_LH, 16'h0, 32'h80007FFF, 2'd3, 5'd17);
    nAssert++;
    if (out_data !== 32'hFFFF8000 || out_err !== expErr) begin
      nFail++; $display("FAIL lh_off3: got %h err %b want ffff8000 err %b", out_data, out_err, expErr);
    end
    driveReq(EXT_LHU, 16'h0, 32'h80007FFF, 2'd0, 5'd18);
    nAssert++;
    if (out_data !== 32'h00007FFF || out_err !== 1'b0) begin
      nFail++; $display("FAIL lhu_off0: got %h err %b want 00007fff err 0", out_data, out_err);
    end
    driveReq(EXT_LHU, 16'h0, 32'h80007FFF, 2'd2, 5'd19);
    nAssert++;
    if (out_data !== 32'h00008000) begin nFail++; $display("FAIL lhu_off2: got %h want 00008000", out_data); end
    driveReq(EXT_LW, 16'h0, 32'h80007FFF, 2'd1, 5'd20);
    nAssert++;
    if (out_data !== 32'h80007FFF || out_tag !== 5'd20) begin
      nFail++; $display("FAIL lw: got %h tag %0d want 80007fff tag 20", out_data, out_tag);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] words [3];
    words = '{32'hDEADBEEF, 32'h01234567, 32'hCAFEF00D};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = EXT_LW;
    for (int i = 0; i < 3; i++) begin
      in_word = words[i];
      in_tag  = 5'(21 + i);
      @(negedge clk);
      nAssert++;
      if (out_valid !== 1'b1 || out_data !== words[i] || out_tag !== 5'(21 + i) || in_ready !== 1'b1) begin
        nFail++;
        $display("FAIL b2b_%0d: got v%b %h tag %0d rdy %b want v1 %h tag %0d rdy 1",
                 i, out_valid, out_data, out_tag, in_ready, words[i], 21 + i);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    nAssert++;
    if (out_valid !== 1'b0) begin nFail++; $display("FAIL b2b_tail: got v%b want 0", out_valid); end
  endtask

  task automatic test_back_pressure;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = EXT_ZERO;
    in_imm    = 16'd1;
    in_tag    = 5'd1;
    @(negedge clk);
    nAssert++;
    if (out_valid !== 1'b1 || out_tag !== 5'd1 || in_ready !== 1'b1) begin
      nFail++; $display("FAIL bp_first: got v%b tag %0d rdy %b want v1 tag 1 rdy 1", out_valid, out_tag, in_ready);
    end
    in_imm = 16'd2;
    in_tag = 5'd2;
    @(negedge clk);
    nAssert++;
    if (in_ready !== 1'b0 || out_tag !== 5'd1) begin
      nFail++; $display("FAIL bp_skid_full: got rdy %b tag %0d want rdy 0 tag 1", in_ready, out_tag);
    end
    in_imm = 16'd3;
    in_tag = 5'd3;
    repeat (2) @(negedge clk);
    nAssert++;
    if (out_valid !== 1'b1 || out_tag !== 5'd1 || out_data !== 32'd1 || in_ready !== 1'b0) begin
      nFail++;
      $display("FAIL bp_hold: got v%b %h tag %0d rdy %b want v1 00000001 tag 1 rdy 0",
               out_valid, out_data, out_tag, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    nAssert++;
    if (out_valid !== 1'b1 || out_tag !== 5'd2 || out_data !== 32'd2 || in_ready !== 1'b1) begin
      nFail++;
      $display("FAIL bp_drain2: got v%b %h tag %0d rdy %b want v1 00000002 tag 2 rdy 1",
               out_valid, out_data, out_tag, in_ready);
    end
    @(negedge clk);
    nAssert++;
    if (out_valid !== 1'b1 || out_tag !== 5'd3 || out_data !== 32'd3) begin
      nFail++; $display("FAIL bp_drain3: got v%b %h tag %0d want v1 00000003 tag 3", out_valid, out_data, out_tag);
    end
    in_valid = 1'b0;
    @(negedge clk);
    nAssert++;
    if (out_valid !== 1'b0) begin nFail++; $display("FAIL bp_no_dup: got v%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = EXT_ZERO;
    in_imm    = 16'h0044;
    in_tag    = 5'd4;
    @(negedge clk);
    in_imm = 16'h0055;
    in_tag = 5'd5;
    @(negedge clk);
    in_valid = 1'b0;
    nAssert++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      nFail++; $display("FAIL rm_full: got v%b rdy %b want v1 rdy 0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    nAssert++;
    if (in_ready !== 1'b0) begin nFail++; $display("FAIL rm_ready_low: got %b want 0", in_ready); end
    @(negedge clk);
    nAssert++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'd0 || in_ready !== 1'b0) begin
      nFail++;
      $display("FAIL rm_cleared: got v%b %h tag %0d rdy %b want v0 00000000 tag 0 rdy 0",
               out_valid, out_data, out_tag, in_ready);
    end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    nAssert++;
    if (in_ready !== 1'b1) begin nFail++; $display("FAIL rm_ready_back: got %b want 1", in_ready); end
    @(negedge clk);
    nAssert++;
    if (out_valid !== 1'b0) begin nFail++; $display("FAIL rm_no_stale: got v%b want 0", out_valid); end
    driveReq(EXT_SIGN, 16'h7FFF, 32'h0, 2'd0, 5'd9);
    nAssert++;
    if (out_valid !== 1'b1 || out_data !== 32'h00007FFF || out_tag !== 5'd9) begin
      nFail++; $display("FAIL rm_first_req: got v%b %h tag %0d want v1 00007fff tag 9", out_valid, out_data, out_tag);
    end
  endtask

  initial begin
    nAssert   = 0;
    nFail     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 3'd0;
    in_imm    = '0;
    in_word   = '0;
    in_off    = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    test_reset();
    test_imm_modes();
    test_load_byte();
    test_load_half();
    test_back_to_back();
    test_back_pressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
